xy_input_conditioner: RTL and testbench
=======================================

XY_INPUT_CONDITIONER -- requirements
Module: xy_input_conditioner

Interface
REQ-001 Parameter SYNC_STAGES SHALL default to 2: the number of synchronizer flops per raw input; legal range is at least 2.
REQ-002 Parameter DB_CYCLES SHALL default to 4: the number of consecutive agreeing synchronized samples needed to change a debounced level; legal range is 2 to 65535.
REQ-003 Port clk SHALL be an input, 1 bit wide: the system clock; all state updates occur on its rising edge.
REQ-004 Port rst SHALL be an input, 1 bit wide: the reset, which is synchronous and active-high.
REQ-005 Ports x_raw and y_raw SHALL be inputs, 1 bit each: asynchronous, bouncy switch or button levels.
REQ-006 Ports x and y SHALL be outputs, 1 bit each: the debounced levels, which feed a negedge-sampled control FSM.
REQ-007 Ports x_rise and y_rise SHALL be outputs, 1 bit each: one-cycle pulses marking a debounced 0->1 change.
REQ-008 Ports x_fall and y_fall SHALL be outputs, 1 bit each: one-cycle pulses marking a debounced 1->0 change.
REQ-009 Port busy SHALL be an output, 1 bit wide: high while either channel is in a pending state.

Function
REQ-010 Each channel SHALL pass its raw input through a SYNC_STAGES-deep flop chain; the last stage is called "sync".
REQ-011 Each channel SHALL run an independent 4-state FSM with states DB_LOW, DB_PEND_HIGH, DB_HIGH and DB_PEND_LOW, plus a counter cnt that is ceil(log2(DB_CYCLES+1)) bits wide.
REQ-012 Transitions out of DB_LOW SHALL be:
- sync=1: go to DB_PEND_HIGH and set cnt=1.
- otherwise: stay, with cnt=0.
REQ-013 Transitions out of DB_PEND_HIGH SHALL be:
- sync=0: return to DB_LOW and set cnt=0.
- sync=1 and cnt==DB_CYCLES-1: go to DB_HIGH and set cnt=0.
- otherwise: increment cnt.
REQ-014 DB_HIGH and DB_PEND_LOW SHALL mirror REQ-012 and REQ-013 with the polarity of sync inverted, finally returning to DB_LOW.
REQ-015 Output x (and likewise y) SHALL be registered and equal 1 exactly when the channel is in DB_HIGH or DB_PEND_LOW.
REQ-016 The rise and fall pulses SHALL be registered and high for exactly the one cycle following the edge on which the debounced level changes.
REQ-017 Latency: a raw change first sampled at rising edge k, and held stable thereafter, SHALL update the debounced output at edge k+SYNC_STAGES+DB_CYCLES-1.
REQ-018 Glitch rejection: a synchronized excursion of at most DB_CYCLES-1 cycles SHALL leave the level unchanged and produce no pulse.
REQ-019 An excursion that ends exactly on the terminal-count edge SHALL NOT commit, because the sync value on that edge disagrees.
REQ-020 The channels SHALL be fully independent: simultaneous x and y changes commit on the same edge when their timing is identical.
REQ-021 Outputs SHALL change only on rising clk edges, so they are stable at the following falling edge.
REQ-022 busy SHALL be combinational: the OR of "channel in a PEND state" across both channels.
REQ-023 The counter SHALL never wrap: it is bounded by DB_CYCLES-1 and cleared on every exit from a PEND state.

Reset
REQ-024 While rst=1 at a rising edge, the block SHALL, on that edge:
- clear all synchronizer flops;
- put both FSMs in DB_LOW with cnt=0;
- drive x, y, all rise/fall pulses and busy to 0.
REQ-025 A reset asserted mid-PEND or mid-pulse SHALL abort it with no pulse emitted; a rise pulse is also not emitted after rst releases while the raw input is still 0.
REQ-026 If a raw input is held high through reset release, it SHALL take the full latency of REQ-017, measured from the first post-reset edge, to produce its rise pulse.

Structure
REQ-027 The enum db_state_t and the constants DEF_SYNC_STAGES=2 and DEF_DB_CYCLES=4 SHALL live in the shared package xy_cond_pkg.
REQ-028 One sub-module, debounce_channel, SHALL contain the synchronizer, FSM, counter and pulse logic, and the top level SHALL instantiate it twice.
REQ-029 The design SHALL contain no latches, no internally generated clocks, and no logic on the clk path.

Verification
REQ-030 Defaults, rst released, x_raw set to 1 before edge 0 and held: x=1 after edge 5, x_rise high only in the cycle after edge 5, busy high after edges 2 through 4 and low after edge 5.
REQ-031 Defaults, x_raw high for 3 cycles then low: x stays 0, x_rise never fires, busy returns to 0.
REQ-032 Defaults, x settled high, then x_raw toggling 1,0,1,0 each cycle for 10 cycles and finally held low: x stays 1 until 4 stable low samples occur, then exactly one x_fall pulse.
REQ-033 x_raw and y_raw raised on the same cycle: x_rise and y_rise are both asserted in the same single cycle.
REQ-034 rst asserted while x is in DB_PEND_HIGH with cnt=2: after that edge all outputs are 0, and no x_rise occurs until a new full latency elapses.
REQ-035 DB_CYCLES=2 and SYNC_STAGES=3: raw change sampled at edge 0 gives a level change after edge 4; a 1-cycle glitch is rejected.

Source files
------------

// File: rtl/xy_cond_pkg.sv
// Shared types and defaults for the X/Y switch conditioner.
// Holds the per-channel debounce state encoding and a small state-decode helper.
package xy_cond_pkg;

    localparam int DEF_SYNC_STAGES = 2;
    localparam int DEF_DB_CYCLES   = 4;

    typedef enum logic [1:0] {
        DB_LOW       = 2'd0,
        DB_PEND_HIGH = 2'd1,
        DB_HIGH      = 2'd2,
        DB_PEND_LOW  = 2'd3
    } db_state_t;

    function automatic logic is_pend(input logic [1:0] s);
        return (s == DB_PEND_HIGH) || (s == DB_PEND_LOW);
    endfunction

endpackage

// File: rtl/xy_input_conditioner_debounce_channel.sv
// One debounced input: synchronizer chain, 4-state debounce FSM with agree counter,
// registered level and one-cycle rise/fall pulses. o_state exposes the FSM state.
module debounce_channel
    import xy_cond_pkg::*;
#(
    parameter int SYNC_STAGES = DEF_SYNC_STAGES,
    parameter int DB_CYCLES   = DEF_DB_CYCLES
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       i_raw,
    output logic       o_level,
    output logic       o_rise,
    output logic       o_fall,
    output logic [1:0] o_state
);

    localparam int CNT_W = $clog2(DB_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_TERM = CNT_W'(DB_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    logic [SYNC_STAGES-1:0] r_sync;
    logic                   w_sync;
    db_state_t              r_state;
    logic [CNT_W-1:0]       r_cnt;
    logic                   r_level;
    logic                   r_rise;
    logic                   r_fall;

    always_ff @(posedge clk) begin
        if (rst) r_sync <= '0;
        else     r_sync <= {r_sync[SYNC_STAGES-2:0], i_raw};
    end

    assign w_sync = r_sync[SYNC_STAGES-1];

    // Counter counts agreeing samples; it is cleared on every exit from a PEND state.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= DB_LOW;
            r_cnt   <= '0;
            r_level <= 1'b0;
            r_rise  <= 1'b0;
            r_fall  <= 1'b0;
        end else begin
            r_rise <= 1'b0;
            r_fall <= 1'b0;
            case (r_state)
                DB_LOW: begin
                    if (w_sync) begin
                        r_state <= DB_PEND_HIGH;
                        r_cnt   <= CNT_ONE;
                    end else begin
                        r_cnt <= '0;
                    end
                end
                DB_PEND_HIGH: begin
                    if (!w_sync) begin
                        r_state <= DB_LOW;
                        r_cnt   <= '0;
                    end else if (r_cnt == CNT_TERM) begin
                        r_state <= DB_HIGH;
                        r_cnt   <= '0;
                        r_level <= 1'b1;
                        r_rise  <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt + CNT_ONE;
                    end
                end
                DB_HIGH: begin
                    if (!w_sync) begin
                        r_state <= DB_PEND_LOW;
                        r_cnt   <= CNT_ONE;
                    end else begin
                        r_cnt <= '0;
                    end
                end
                DB_PEND_LOW: begin
                    if (w_sync) begin
                        r_state <= DB_HIGH;
                        r_cnt   <= '0;
                    end else if (r_cnt == CNT_TERM) begin
                        r_state <= DB_LOW;
                        r_cnt   <= '0;
                        r_level <= 1'b0;
                        r_fall  <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt + CNT_ONE;
                    end
                end
                default: begin
                    r_state <= DB_LOW;
                    r_cnt   <= '0;
                    r_level <= 1'b0;
                end
            endcase
        end
    end

    assign o_level = r_level;
    assign o_rise  = r_rise;
    assign o_fall  = r_fall;
    assign o_state = r_state;

endmodule

// File: rtl/xy_input_conditioner.sv
// Conditions two asynchronous bouncy inputs into clean debounced levels and edge pulses.
// busy flags that either channel is still deciding on a pending change.
module xy_input_conditioner
    import xy_cond_pkg::*;
#(
    parameter int SYNC_STAGES = DEF_SYNC_STAGES,
    parameter int DB_CYCLES   = DEF_DB_CYCLES
) (
    input  logic clk,
    input  logic rst,
    input  logic x_raw,
    input  logic y_raw,
    output logic x,
    output logic y,
    output logic x_rise,
    output logic y_rise,
    output logic x_fall,
    output logic y_fall,
    output logic busy
);

    logic [1:0] w_x_state;
    logic [1:0] w_y_state;

    debounce_channel #(
        .SYNC_STAGES(SYNC_STAGES),
        .DB_CYCLES  (DB_CYCLES)
    ) u_x (
        .clk    (clk),
        .rst    (rst),
        .i_raw  (x_raw),
        .o_level(x),
        .o_rise (x_rise),
        .o_fall (x_fall),
        .o_state(w_x_state)
    );

    debounce_channel #(
        .SYNC_STAGES(SYNC_STAGES),
        .DB_CYCLES  (DB_CYCLES)
    ) u_y (
        .clk    (clk),
        .rst    (rst),
        .i_raw  (y_raw),
        .o_level(y),
        .o_rise (y_rise),
        .o_fall (y_fall),
        .o_state(w_y_state)
    );

    assign busy = is_pend(w_x_state) | is_pend(w_y_state);

endmodule

// File: tb/tb_xy_input_conditioner.sv
// Directed bench for xy_input_conditioner: default instance plus a DB_CYCLES=2,
// SYNC_STAGES=3 instance. Inputs change and outputs are checked on falling edges.
module tb_xy_input_conditioner;

    logic clk;
    logic rst;
    logic x_raw, y_raw;
    logic x, y, x_rise, y_rise, x_fall, y_fall, busy;
    logic x2_raw, y2_raw;
    logic x2, y2, x2_rise, y2_rise, x2_fall, y2_fall, busy2;

    int n_cmp = 0;
    int n_err = 0;
    logic [0:0] exp_q[$];

    xy_input_conditioner dut (
        .clk(clk), .rst(rst), .x_raw(x_raw), .y_raw(y_raw),
        .x(x), .y(y), .x_rise(x_rise), .y_rise(y_rise),
        .x_fall(x_fall), .y_fall(y_fall), .busy(busy)
    );

    xy_input_conditioner #(.SYNC_STAGES(3), .DB_CYCLES(2)) dut2 (
        .clk(clk), .rst(rst), .x_raw(x2_raw), .y_raw(y2_raw),
        .x(x2), .y(y2), .x_rise(x2_rise), .y_rise(y2_rise),
        .x_fall(x2_fall), .y_fall(y2_fall), .busy(busy2)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // driver tasks: each tick advances exactly one rising edge, ending at the falling edge
    task automatic tick();
        @(negedge clk);
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_all_zero(input string tag);
        chk(tag, {25'd0, x, y, x_rise, y_rise, x_fall, y_fall, busy}, 32'd0);
    endtask

    initial begin
        logic [0:0] exp_busy;
        logic seen;
        rst = 1'b1; x_raw = 1'b0; y_raw = 1'b0; x2_raw = 1'b0; y2_raw = 1'b0;
        tick(); tick();
        chk_all_zero("reset_state");
        chk("reset_state_dut2", {28'd0, x2, y2, x2_rise, busy2}, 32'd0);

        // Basic latency: raw high sampled at edge 0 commits at edge 5
        rst = 1'b0; x_raw = 1'b1;
        exp_q.push_back(1'b0); exp_q.push_back(1'b0); exp_q.push_back(1'b1);
        exp_q.push_back(1'b1); exp_q.push_back(1'b1); exp_q.push_back(1'b0);
        for (int n = 0; n < 6; n++) begin
            tick();
            exp_busy = exp_q.pop_front();
            chk($sformatf("lat_busy_e%0d", n), {31'd0, busy}, {31'd0, exp_busy});
            chk($sformatf("lat_x_e%0d", n), {31'd0, x}, (n == 5) ? 32'd1 : 32'd0);
            chk($sformatf("lat_rise_e%0d", n), {31'd0, x_rise}, (n == 5) ? 32'd1 : 32'd0);
        end
        tick();
        chk("lat_rise_one_cycle", {31'd0, x_rise}, 32'd0);
        chk("lat_x_held", {31'd0, x}, 32'd1);

        // Reset while settled high clears everything
        rst = 1'b1; x_raw = 1'b0;
        tick();
        chk_all_zero("reset_from_high");
        rst = 1'b0;
        ticks(4);

        // 3-cycle excursion is rejected (ends on the terminal-count edge)
        x_raw = 1'b1;
        ticks(3);
        x_raw = 1'b0;
        seen = 1'b0;
        for (int n = 0; n < 8; n++) begin
            tick();
            if (x || x_rise) seen = 1'b1;
        end
        chk("glitch3_no_commit", {31'd0, seen}, 32'd0);
        chk("glitch3_busy_idle", {31'd0, busy}, 32'd0);

        // Settle high, then bounce, then hold low
        x_raw = 1'b1;
        ticks(8);
        chk("settle_high", {31'd0, x}, 32'd1);
        seen = 1'b0;
        for (int i = 0; i < 10; i++) begin
            x_raw = (i % 2 == 0) ? 1'b1 : 1'b0;
            tick();
            if (!x || x_fall) seen = 1'b1;
        end
        chk("bounce_level_held", {31'd0, seen}, 32'd0);
        for (int j = 1; j <= 4; j++) begin
            tick();
            chk($sformatf("bounce_wait_x_%0d", j), {31'd0, x}, 32'd1);
            chk($sformatf("bounce_wait_fall_%0d", j), {31'd0, x_fall}, 32'd0);
        end
        tick();
        chk("bounce_fall_x", {31'd0, x}, 32'd0);
        chk("bounce_fall_pulse", {31'd0, x_fall}, 32'd1);
        tick();
        chk("bounce_fall_one_cycle", {31'd0, x_fall}, 32'd0);

        // Simultaneous x and y rise commit on the same edge
        ticks(4);
        x_raw = 1'b1; y_raw = 1'b1;
        for (int j = 1; j <= 5; j++) begin
            tick();
            chk($sformatf("xy_pre_rise_%0d", j), {30'd0, x_rise, y_rise}, 32'd0);
        end
        tick();
        chk("xy_rise_both", {30'd0, x_rise, y_rise}, 32'd3);
        chk("xy_level_both", {30'd0, x, y}, 32'd3);
        tick();
        chk("xy_rise_one_cycle", {30'd0, x_rise, y_rise}, 32'd0);

        // Reset mid-PEND_HIGH (cnt=2), raw held high through release
        rst = 1'b1; x_raw = 1'b0; y_raw = 1'b0;
        tick();
        rst = 1'b0;
        ticks(4);
        x_raw = 1'b1;
        ticks(4);
        chk("pend_before_reset_busy", {31'd0, busy}, 32'd1);
        rst = 1'b1;
        tick();
        chk_all_zero("reset_mid_pend");
        rst = 1'b0;
        for (int j = 1; j <= 5; j++) begin
            tick();
            chk($sformatf("post_reset_no_rise_%0d", j), {30'd0, x, x_rise}, 32'd0);
        end
        tick();
        chk("post_reset_full_latency", {30'd0, x, x_rise}, 32'd3);

        // Short-configuration instance: latency 4 edges, 1-cycle glitch rejected
        x2_raw = 1'b1;
        ticks(4);
        chk("dut2_pre_commit", {30'd0, x2, x2_rise}, 32'd0);
        tick();
        chk("dut2_commit", {30'd0, x2, x2_rise}, 32'd3);
        ticks(3);
        x2_raw = 1'b0;
        tick();
        x2_raw = 1'b1;
        seen = 1'b0;
        for (int n = 0; n < 8; n++) begin
            tick();
            if (!x2 || x2_fall) seen = 1'b1;
        end
        chk("dut2_glitch_rejected", {31'd0, seen}, 32'd0);
        chk("dut2_y_idle", {30'd0, y2, y2_rise}, 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
